// File: rtl/p405s_dcu_rdparchk.sv
// DCU load-return stage: way select, byte parity check, registered load data and machine-check syndrome.
// Optional DCU_PARERR_CNT_EN adds a saturating error-event counter (errCnt) with clear input (errCntClr).
module p405s_dcu_rdparchk #(
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic        CB,
    input  logic        resetCore_N,
    input  logic [0:31] wordMuxA,
    input  logic [0:31] wordMuxB,
    input  logic [0:3]  p_ramBypassA,
    input  logic [0:3]  p_ramBypassB,
    input  logic        rdValid,
    input  logic        hitA,
    input  logic        hitB,
    input  logic        flush,
    input  logic        parChkEn,
    input  logic        mchkAck,
    output logic [0:31] loadData,
    output logic        loadDataVld,
    output logic        loadDataErr,
    output logic        mchkReq,
    output logic [0:1]  synWay,
    output logic [0:3]  synByte,
    output logic        synOvf
`ifdef DCU_PARERR_CNT_EN
    ,
    input  logic        errCntClr,
    output logic [0:7]  errCnt
`endif
);

    typedef enum logic {IDLE = 1'b0, REPORT = 1'b1} state_t;

    state_t      state_reg, state_next;
    logic [0:31] load_data_reg;
    logic        load_vld_reg, load_err_reg;
    logic [0:1]  syn_way_reg, syn_way_next;
    logic [0:3]  syn_byte_reg, syn_byte_next;
    logic        syn_ovf_reg, syn_ovf_next;

    logic        accept, multi_hit, err_ev, any_err;
    logic [0:31] sel_word;
    logic [0:3]  sel_par, byte_err, new_byte;
    logic [0:1]  new_way;

    assign accept    = rdValid & ~flush & (hitA | hitB);
    assign multi_hit = hitA & hitB;
    // A wins the data mux on a multi-hit; the multi-hit itself is the error.
    assign sel_word  = hitA ? wordMuxA : wordMuxB;
    assign sel_par   = hitA ? p_ramBypassA : p_ramBypassB;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte_chk
            assign byte_err[gi] = parChkEn & (^sel_word[8*gi +: 8] ^ sel_par[gi] ^ PARITY_ODD);
        end
    endgenerate

    assign any_err  = (|byte_err) | multi_hit;
    assign err_ev   = accept & any_err;
    assign new_way  = multi_hit ? 2'b11 : (hitA ? 2'b10 : 2'b01);
    assign new_byte = multi_hit ? 4'b0000 : byte_err;

    always_ff @(posedge CB or negedge resetCore_N) begin
        if (!resetCore_N) begin
            load_data_reg <= '0;
            load_vld_reg  <= 1'b0;
            load_err_reg  <= 1'b0;
        end else begin
            load_vld_reg <= accept;
            load_err_reg <= err_ev;
            if (accept) begin
                load_data_reg <= sel_word;
            end
        end
    end

    always_ff @(posedge CB or negedge resetCore_N) begin
        if (!resetCore_N) begin
            state_reg    <= IDLE;
            syn_way_reg  <= '0;
            syn_byte_reg <= '0;
            syn_ovf_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            syn_way_reg  <= syn_way_next;
            syn_byte_reg <= syn_byte_next;
            syn_ovf_reg  <= syn_ovf_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        syn_way_next  = syn_way_reg;
        syn_byte_next = syn_byte_reg;
        syn_ovf_next  = syn_ovf_reg;
        case (state_reg)
            IDLE: begin
                if (err_ev) begin
                    state_next    = REPORT;
                    syn_way_next  = new_way;
                    syn_byte_next = new_byte;
                    syn_ovf_next  = 1'b0;
                end
            end
            REPORT: begin
                if (mchkAck && err_ev) begin
                    // Ack retires the old report; the new error immediately becomes the next one.
                    syn_way_next  = new_way;
                    syn_byte_next = new_byte;
                    syn_ovf_next  = 1'b0;
                end else if (err_ev) begin
                    syn_ovf_next  = 1'b1;
                end else if (mchkAck) begin
                    state_next    = IDLE;
                    syn_way_next  = '0;
                    syn_byte_next = '0;
                    syn_ovf_next  = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef DCU_PARERR_CNT_EN
    logic [0:7] err_cnt_reg;

    always_ff @(posedge CB or negedge resetCore_N) begin
        if (!resetCore_N) begin
            err_cnt_reg <= '0;
        end else if (errCntClr) begin
            err_cnt_reg <= '0;
        end else if (err_ev && (err_cnt_reg != 8'hFF)) begin
            err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    assign errCnt = err_cnt_reg;
`endif

    assign loadData    = load_data_reg;
    assign loadDataVld = load_vld_reg;
    assign loadDataErr = load_err_reg;
    assign mchkReq     = (state_reg == REPORT);
    assign synWay      = syn_way_reg;
    assign synByte     = syn_byte_reg;
    assign synOvf      = syn_ovf_reg;

endmodule

// File: tb/tb_p405s_dcu_rdparchk.sv
// Directed + random bench for p405s_dcu_rdparchk: load-data scoreboard plus a behavioural syndrome/FSM model.
module tb_p405s_dcu_rdparchk;

    logic        CB = 1'b0;
    logic        resetCore_N = 1'b0;
    logic [0:31] wordMuxA = '0, wordMuxB = '0;
    logic [0:3]  p_ramBypassA = '0, p_ramBypassB = '0;
    logic        rdValid = 0, hitA = 0, hitB = 0, flush = 0, parChkEn = 0, mchkAck = 0;
    logic [0:31] loadData;
    logic        loadDataVld, loadDataErr, mchkReq, synOvf;
    logic [0:1]  synWay;
    logic [0:3]  synByte;
    logic        errCntClr = 1'b0;
`ifdef DCU_PARERR_CNT_EN
    logic [0:7]  errCnt;
`endif

    p405s_dcu_rdparchk #(.PARITY_ODD(1'b0)) dut (
        .CB(CB), .resetCore_N(resetCore_N),
        .wordMuxA(wordMuxA), .wordMuxB(wordMuxB),
        .p_ramBypassA(p_ramBypassA), .p_ramBypassB(p_ramBypassB),
        .rdValid(rdValid), .hitA(hitA), .hitB(hitB), .flush(flush),
        .parChkEn(parChkEn), .mchkAck(mchkAck),
        .loadData(loadData), .loadDataVld(loadDataVld), .loadDataErr(loadDataErr),
        .mchkReq(mchkReq), .synWay(synWay), .synByte(synByte), .synOvf(synOvf)
`ifdef DCU_PARERR_CNT_EN
        , .errCntClr(errCntClr), .errCnt(errCnt)
`endif
    );

    always #5 CB = ~CB;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_step = 0;
    logic [31:0] m_last_data = '0;
    logic        m_req = 0, m_ovf = 0;
    logic [1:0]  m_way = '0;
    logic [3:0]  m_byte = '0;
    int          m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_last_data = '0;
        m_req = 0; m_ovf = 0; m_way = '0; m_byte = '0; m_cnt = 0;
    endtask

    // One bus cycle: drive, predict, clock, then compare everything the DUT exposes.
    task automatic step(input logic rv, ha, hb, fl, en, ack,
                        input logic [31:0] a, b, input logic [3:0] pa, pb, input logic clr);
        logic        acc, multi, ev;
        logic [31:0] w;
        logic [3:0]  p, e;
        logic [1:0]  nway;
        exp_t        x;
        rdValid = rv; hitA = ha; hitB = hb; flush = fl; parChkEn = en; mchkAck = ack;
        wordMuxA = a; wordMuxB = b; p_ramBypassA = pa; p_ramBypassB = pb; errCntClr = clr;
        acc   = rv & ~fl & (ha | hb);
        multi = ha & hb;
        w     = ha ? a : b;
        p     = ha ? pa : pb;
        // byte 0 is the most significant byte; its parity is the MSB of the 4-bit field
        for (int i = 0; i < 4; i++)
            e[3-i] = en & ((^w[31-8*i -: 8]) ^ p[3-i]);
        ev   = acc & ((|e) | multi);
        nway = multi ? 2'b11 : (ha ? 2'b10 : 2'b01);
        if (acc) begin
            x.data = w; x.err = ev;
            sb.push_back(x);
        end
        if (!m_req) begin
            if (ev) begin m_req = 1; m_way = nway; m_byte = multi ? 4'b0 : e; m_ovf = 0; end
        end else if (ack && ev) begin
            m_way = nway; m_byte = multi ? 4'b0 : e; m_ovf = 0;
        end else if (ev) begin
            m_ovf = 1;
        end else if (ack) begin
            m_req = 0; m_way = '0; m_byte = '0; m_ovf = 0;
        end
        if (clr) m_cnt = 0;
        else if (ev && m_cnt < 255) m_cnt++;

        @(posedge CB); #1;
        n_step++;
        if (sb.size() != 0) begin
            x = sb.pop_front();
            m_last_data = x.data;
            chk("vld", {31'b0, loadDataVld}, 32'd1);
            chk("err", {31'b0, loadDataErr}, {31'b0, x.err});
        end else begin
            chk("vld", {31'b0, loadDataVld}, 32'd0);
        end
        chk("data", loadData, m_last_data);
        chk("req", {31'b0, mchkReq}, {31'b0, m_req});
        chk("way", {30'b0, synWay}, {30'b0, m_way});
        chk("byte", {28'b0, synByte}, {28'b0, m_byte});
        chk("ovf", {31'b0, synOvf}, {31'b0, m_ovf});
`ifdef DCU_PARERR_CNT_EN
        chk("cnt", {24'b0, errCnt}, m_cnt);
`endif
        $display("step %0d acc=%0b ev=%0b data=%h req=%0b way=%b byte=%b ovf=%0b",
                 n_step, acc, ev, loadData, mchkReq, synWay, synByte, synOvf);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"}, loadData, 32'd0);
        chk({tag, "_vld"}, {31'b0, loadDataVld}, 32'd0);
        chk({tag, "_err"}, {31'b0, loadDataErr}, 32'd0);
        chk({tag, "_req"}, {31'b0, mchkReq}, 32'd0);
        chk({tag, "_syn"}, {25'b0, synWay, synByte, synOvf}, 32'd0);
`ifdef DCU_PARERR_CNT_EN
        chk({tag, "_cnt"}, {24'b0, errCnt}, 32'd0);
`endif
    endtask

    localparam logic [31:0] W = 32'h01020304;

    initial begin
        // bytes 01,02,03,04 have parities 1,1,0,1 -> 4'b1101 is clean under even parity
        repeat (2) @(posedge CB);
        #1 chk_all_zero("rst");
        resetCore_N = 1'b1;
        model_reset();

        step(1, 1, 0, 0, 1, 0, W, '0, 4'b1101, '0, 0);
        chk("good_noreq", {31'b0, mchkReq}, 32'd0);
        step(1, 1, 0, 0, 1, 0, W, '0, 4'b1111, '0, 0);
        step(0, 0, 0, 0, 1, 0, '0, '0, '0, '0, 0);
        chk("bad_way", {30'b0, synWay}, 32'd2);
        chk("bad_byte", {28'b0, synByte}, 32'd2);
        step(0, 0, 0, 0, 1, 1, '0, '0, '0, '0, 0);
        chk("ack_clr", {31'b0, mchkReq}, 32'd0);
        step(0, 0, 0, 0, 1, 1, '0, '0, '0, '0, 0);
        step(1, 0, 1, 1, 1, 0, '0, W, '0, 4'b1111, 0);
        step(1, 0, 1, 0, 0, 0, '0, W, '0, 4'b1111, 0);
        step(1, 0, 0, 0, 1, 0, W, W, 4'b1111, 4'b1111, 0);
        step(1, 1, 1, 0, 1, 0, W, 32'hDEADBEEF, 4'b1101, 4'b0000, 0);
        chk("mh_way", {30'b0, synWay}, 32'd3);
        chk("mh_byte", {28'b0, synByte}, 32'd0);
        step(1, 1, 0, 0, 1, 0, W, '0, 4'b1111, '0, 0);
        chk("ovf_set", {31'b0, synOvf}, 32'd1);
        chk("ovf_way", {30'b0, synWay}, 32'd3);
        step(1, 0, 1, 0, 1, 1, '0, W, '0, 4'b0101, 0);
        chk("col_req", {31'b0, mchkReq}, 32'd1);
        chk("col_way", {30'b0, synWay}, 32'd1);
        chk("col_byte", {28'b0, synByte}, 32'd8);
        chk("col_ovf", {31'b0, synOvf}, 32'd0);
        step(0, 0, 0, 0, 1, 1, '0, '0, '0, '0, 0);

        for (int i = 0; i < 40; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                 $urandom, $urandom, 4'($urandom), 4'($urandom), 0);

`ifdef DCU_PARERR_CNT_EN
        step(0, 0, 0, 0, 1, 0, '0, '0, '0, '0, 1);
        for (int i = 0; i < 257; i++)
            step(1, 1, 0, 0, 1, 0, W, '0, 4'b1111, '0, 0);
        chk("cnt_sat", {24'b0, errCnt}, 32'hFF);
        step(1, 1, 0, 0, 1, 0, W, '0, 4'b1111, '0, 1);
        chk("cnt_clr", {24'b0, errCnt}, 32'd0);
        step(1, 1, 0, 0, 1, 0, W, '0, 4'b1111, '0, 0);
`endif

        step(1, 1, 0, 0, 1, 0, W, '0, 4'b1111, '0, 0);
        chk("pre_rst_req", {31'b0, mchkReq}, 32'd1);
        #2 resetCore_N = 1'b0;
        #1 chk_all_zero("async_rst");
        @(posedge CB); #1;
        resetCore_N = 1'b1;
        model_reset();
        step(0, 0, 0, 0, 1, 0, '0, '0, '0, '0, 0);
        step(1, 0, 1, 0, 1, 0, '0, W, '0, 4'b1101, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
